pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 144 ++++++++++++++
 tb/tb_pipeline_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - pipeline stall/flush/memory-wait controller
// Same-cycle enables and flushes; registered state, event counters and timeout flag.
module pipeline_controller #(
  parameter int TimeoutCycles = 15,
  parameter int CountBits     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Load_Use_Hazard,
  input  logic                 Branch_Taken,
  input  logic                 Mem_Req,
  input  logic                 Mem_Ready,
  input  logic                 Halt,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 EX_MEM_Write,
  output logic                 MEM_WB_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic                 Mem_Timeout,
  output logic                 Halted,
  output logic [1:0]           State,
  output logic [CountBits-1:0] Stall_Count,
  output logic [CountBits-1:0] Flush_Count
);

  localparam int WaitBits = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [WaitBits-1:0]  WaitMax  = WaitBits'(TimeoutCycles);
  localparam logic [CountBits-1:0] CountMax = {CountBits{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b11
  } state_e;

  state_e               state_q, state_d, state_eff;
  logic [WaitBits-1:0]  wait_q, wait_d;
  logic [CountBits-1:0] stall_q, stall_d;
  logic [CountBits-1:0] flush_q, flush_d;
  logic                 timeout_q, timeout_d;
  logic                 stall_inc, flush_inc, run_prio;

  // Outputs follow RUN while reset is held, whatever the registered state.
  assign state_eff = rst ? RUN : state_q;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    run_prio     = 1'b0;
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    EX_MEM_Write = 1'b0;
    MEM_WB_Write = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    Halted       = 1'b0;

    case (state_eff)
      RUN: begin
        if (Halt) begin
          state_d = HALT;
        end else if (Mem_Req && !Mem_Ready) begin
          state_d   = MEM_WAIT;
          wait_d    = WaitBits'(1);
          stall_inc = 1'b1;
        end else begin
          run_prio = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!Mem_Ready) begin
          stall_inc = 1'b1;
          if (wait_q == WaitMax) begin
            timeout_d = 1'b1;
            state_d   = HALT;
          end else begin
            wait_d = wait_q + WaitBits'(1);
          end
        end else begin
          run_prio = 1'b1;
          state_d  = RUN;
        end
      end
      HALT: begin
        Halted = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Branch beats load-use; both share the RUN and MEM_WAIT-ready paths.
    if (run_prio) begin
      if (Branch_Taken) begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        flush_inc    = 1'b1;
      end else if (Load_Use_Hazard) begin
        ID_EX_Flush  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        stall_inc    = 1'b1;
      end else begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
      end
    end

    stall_d = (stall_inc && stall_q != CountMax) ? stall_q + CountBits'(1) : stall_q;
    flush_d = (flush_inc && flush_q != CountMax) ? flush_q + CountBits'(1) : flush_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  assign State       = state_q;
  assign Stall_Count = stall_q;
  assign Flush_Count = flush_q;
  assign Mem_Timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed vector bench for pipeline_controller
module tb_pipeline_controller;

  logic clk = 1'b0;
  logic rst, lu, br, req, rdy, halt;

  logic       pc_w, ifid_w, exm_w, mwb_w, if_fl, id_fl, to, hlt;
  logic [1:0] st;
  logic [7:0] stall, flush;

  logic       pc_w2, ifid_w2, exm_w2, mwb_w2, if_fl2, id_fl2, to2, hlt2;
  logic [1:0] st2;
  logic [1:0] stall2, flush2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_controller dut (
    .clk(clk), .rst(rst), .Load_Use_Hazard(lu), .Branch_Taken(br),
    .Mem_Req(req), .Mem_Ready(rdy), .Halt(halt),
    .PC_Write(pc_w), .IF_ID_Write(ifid_w), .EX_MEM_Write(exm_w), .MEM_WB_Write(mwb_w),
    .IF_ID_Flush(if_fl), .ID_EX_Flush(id_fl), .Mem_Timeout(to), .Halted(hlt),
    .State(st), .Stall_Count(stall), .Flush_Count(flush)
  );

  pipeline_controller #(.TimeoutCycles(15), .CountBits(2)) dut2 (
    .clk(clk), .rst(rst), .Load_Use_Hazard(lu), .Branch_Taken(br),
    .Mem_Req(req), .Mem_Ready(rdy), .Halt(halt),
    .PC_Write(pc_w2), .IF_ID_Write(ifid_w2), .EX_MEM_Write(exm_w2), .MEM_WB_Write(mwb_w2),
    .IF_ID_Flush(if_fl2), .ID_EX_Flush(id_fl2), .Mem_Timeout(to2), .Halted(hlt2),
    .State(st2), .Stall_Count(stall2), .Flush_Count(flush2)
  );

  typedef struct packed {
    logic [5:0] in;    // rst, lu, br, req, rdy, halt
    logic [3:0] wr;    // pc, if_id, ex_mem, mem_wb
    logic [1:0] fl;    // if_id, id_ex
    logic [1:0] st;
    logic       hlt;
    logic       to;
    logic [7:0] stall;
    logic [7:0] flush;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic [5:0] in, logic [3:0] wr, logic [1:0] fl, logic [1:0] s,
                              logic h, logic t, logic [7:0] sc, logic [7:0] fc);
    vec_t v;
    v.in = in; v.wr = wr; v.fl = fl; v.st = s; v.hlt = h; v.to = t; v.stall = sc; v.flush = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] v);
    {rst, lu, br, req, rdy, halt} = v;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [25:0] act;
    int cyc;

    set_in(6'b100000);
    step(); step();

    //                in         wr       fl     st   h  t  stall flush
    vecs[0]  = mk(6'b100000, 4'b1111, 2'b00, 2'd0, 0, 0, 8'd0, 8'd0);
    vecs[1]  = mk(6'b000000, 4'b1111, 2'b00, 2'd0, 0, 0, 8'd0, 8'd0);
    vecs[2]  = mk(6'b010000, 4'b0011, 2'b01, 2'd0, 0, 0, 8'd0, 8'd0);
    vecs[3]  = mk(6'b000000, 4'b1111, 2'b00, 2'd0, 0, 0, 8'd1, 8'd0);
    vecs[4]  = mk(6'b011000, 4'b1111, 2'b11, 2'd0, 0, 0, 8'd1, 8'd0);
    vecs[5]  = mk(6'b000110, 4'b1111, 2'b00, 2'd0, 0, 0, 8'd1, 8'd1);
    vecs[6]  = mk(6'b001100, 4'b0000, 2'b00, 2'd0, 0, 0, 8'd1, 8'd1);
    vecs[7]  = mk(6'b000101, 4'b0000, 2'b00, 2'd1, 0, 0, 8'd2, 8'd1);
    vecs[8]  = mk(6'b010010, 4'b0011, 2'b01, 2'd1, 0, 0, 8'd3, 8'd1);
    vecs[9]  = mk(6'b001001, 4'b0000, 2'b00, 2'd0, 0, 0, 8'd4, 8'd1);
    vecs[10] = mk(6'b011000, 4'b0000, 2'b00, 2'd3, 1, 0, 8'd4, 8'd1);

    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].in);
      #1;
      act = {pc_w, ifid_w, exm_w, mwb_w, if_fl, id_fl, st, hlt, to, stall, flush};
      chk($sformatf("vec%0d", i), 32'(act), 32'(vecs[i][25:0]));
      step();
    end

    // Reset asserted while halted: outputs act as RUN with a taken branch.
    set_in(6'b101000);
    #1;
    chk("rst_in_halt_wr", 32'({pc_w, ifid_w, exm_w, mwb_w}), 32'hf);
    chk("rst_in_halt_fl", 32'({if_fl, id_fl}), 32'h3);
    step();
    chk("rst_exit_state", 32'(st), 32'd0);
    chk("rst_exit_cnt", 32'({stall, flush}), 32'h0);

    // Three not-ready cycles then ready.
    for (int i = 0; i < 3; i++) begin
      set_in(6'b000100);
      #1;
      chk($sformatf("mw%0d_state", i), 32'(st), (i == 0) ? 32'd0 : 32'd1);
      chk($sformatf("mw%0d_wr", i), 32'({pc_w, ifid_w, exm_w, mwb_w}), 32'h0);
      step();
    end
    set_in(6'b000110);
    #1;
    chk("mw_ready_state", 32'(st), 32'd1);
    chk("mw_ready_wr", 32'({pc_w, ifid_w, exm_w, mwb_w}), 32'hf);
    step();
    chk("mw_done_state", 32'(st), 32'd0);
    chk("mw_done_stall", 32'(stall), 32'd3);

    // Memory never ready: timeout after the wait counter reaches 15.
    set_in(6'b100000);
    step();
    set_in(6'b000100);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (cyc == 0 && st == 2'd3) cyc = i;
    end
    chk("to_cycle", 32'(cyc), 32'd16);
    chk("to_flag", 32'({to, st, hlt}), 32'b1111);
    chk("to_stall_frozen", 32'(stall), 32'd16);
    chk("to_halt_wr", 32'({pc_w, ifid_w, exm_w, mwb_w, if_fl, id_fl}), 32'h0);
    set_in(6'b100000);
    step();
    set_in(6'b000000);
    #1;
    chk("to_rst_clear", 32'({to, st, hlt, stall}), 32'h0);

    // Saturation on the 2-bit counter instance.
    set_in(6'b100000);
    step();
    for (int i = 1; i <= 5; i++) begin
      set_in(6'b010000);
      #1;
      chk($sformatf("sat%0d_out2", i),
          32'({pc_w2, ifid_w2, exm_w2, mwb_w2, if_fl2, id_fl2, st2, hlt2, to2, flush2}),
          32'b0011_01_00_0_0_00);
      step();
      chk($sformatf("sat%0d_stall2", i), 32'(stall2), (i > 3) ? 32'd3 : 32'(i));
      chk($sformatf("sat%0d_stall8", i), 32'(stall), 32'(i));
    end
    set_in(6'b000000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
